// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 size codes,
// FSM state encoding and byte-enable width.
package dmem_pkg;

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane steering for the data-memory responder: store byte enables and
// lane replication, legality/alignment check, and load extraction/extension.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [2:0]      i_size,
    input  logic            i_we,
    input  logic [1:0]      i_lane,
    input  logic [31:0]     i_wdata,
    input  logic [31:0]     i_rword,
    output logic [BE_W-1:0] o_be,
    output logic [31:0]     o_wdata_rep,
    output logic            o_illegal,
    output logic [31:0]     o_rdata
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rword >> {i_lane, 3'b000};

    always_comb begin
        o_be        = '0;
        o_wdata_rep = i_wdata;
        o_illegal   = 1'b0;
        o_rdata     = '0;

        case (i_size)
            SZ_B, SZ_BU: begin
                o_be        = 4'b0001 << i_lane;
                o_wdata_rep = {4{i_wdata[7:0]}};
            end
            SZ_H, SZ_HU: begin
                o_be        = 4'b0011 << i_lane;
                o_wdata_rep = {2{i_wdata[15:0]}};
                o_illegal   = i_lane[0];
            end
            SZ_W: begin
                o_be      = 4'b1111;
                o_illegal = (i_lane != 2'b00);
            end
            default: o_illegal = 1'b1;
        endcase

        // Unsigned sizes only make sense for loads.
        if (i_we && (i_size == SZ_BU || i_size == SZ_HU))
            o_illegal = 1'b1;

        case (i_size)
            SZ_B:    o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
            SZ_BU:   o_rdata = {24'd0, w_shifted[7:0]};
            SZ_H:    o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
            SZ_HU:   o_rdata = {16'd0, w_shifted[15:0]};
            SZ_W:    o_rdata = i_rword;
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory slave: one request at a time, WAIT_STATES extra cycles, byte-enabled
// stores, extended loads; handshake is req sampled in IDLE, one-cycle ready pulse.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [2:0]  mem_size_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ready_o,
    output logic        mem_fault_o,
    output logic [1:0]  dbg_state_o
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t r_state;
    state_t w_next;

    logic [3:0]  r_cnt;
    logic        r_we;
    logic [2:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        r_ready;
    logic        r_fault;
    logic [31:0] r_rdata;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic            w_we;
    logic [2:0]      w_size;
    logic [31:0]     w_addr;
    logic [31:0]     w_wdata;
    logic [31:0]     w_off;
    logic [AW-1:0]   w_idx;
    logic            w_in_range;
    logic            w_illegal;
    logic            w_fault;
    logic [BE_W-1:0] w_be;
    logic [31:0]     w_wrep;
    logic [31:0]     w_load;
    logic            w_enter_resp;
    logic            w_commit_store;
    logic [31:0]     w_rdata_nxt;

    // With zero wait states RESP is entered on the capture edge itself, so the
    // live inputs stand in for the not-yet-latched request while in IDLE.
    assign w_we    = (r_state == ST_IDLE) ? mem_we_i    : r_we;
    assign w_size  = (r_state == ST_IDLE) ? mem_size_i  : r_size;
    assign w_addr  = (r_state == ST_IDLE) ? mem_addr_i  : r_addr;
    assign w_wdata = (r_state == ST_IDLE) ? mem_wdata_i : r_wdata;

    assign w_off      = w_addr - BASE_ADDR;
    assign w_in_range = (w_addr >= BASE_ADDR) && (w_off < SPAN);
    assign w_idx      = w_off[AW+1:2];
    assign w_fault    = w_illegal || !w_in_range;

    dmem_lane_unit u_lane (
        .i_size      (w_size),
        .i_we        (w_we),
        .i_lane      (w_addr[1:0]),
        .i_wdata     (w_wdata),
        .i_rword     (r_mem[w_idx]),
        .o_be        (w_be),
        .o_wdata_rep (w_wrep),
        .o_illegal   (w_illegal),
        .o_rdata     (w_load)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (mem_req_i) w_next = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: if (r_cnt == 4'd0) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_enter_resp   = (w_next == ST_RESP) && (r_state != ST_RESP);
        w_commit_store = w_enter_resp && w_we && !w_fault && !reset;
        w_rdata_nxt    = (w_enter_resp && !w_fault && !w_we) ? w_load : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_size  <= 3'd0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == ST_IDLE && mem_req_i) begin
            r_cnt   <= CNT_INIT;
            r_we    <= mem_we_i;
            r_size  <= mem_size_i;
            r_addr  <= mem_addr_i;
            r_wdata <= mem_wdata_i;
        end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_fault <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_enter_resp;
            r_fault <= w_enter_resp && w_fault;
            r_rdata <= w_rdata_nxt;
        end
    end

    // Array contents survive reset; only the committed lanes are touched.
    always_ff @(posedge clk) begin
        if (w_commit_store) begin
            for (int i = 0; i < BE_W; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wrep[8*i +: 8];
            end
        end
    end

    assign mem_ready_o = r_ready;
    assign mem_fault_o = r_fault;
    assign mem_rdata_o = r_rdata;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (1, 0 and 3 wait states) checked
// against a byte-array memory model with directed steps then random requests.
module tb_data_mem_responder;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          NBYTES = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        req   [3];
    logic        we    [3];
    logic [2:0]  sz    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rd    [3];
    logic        rdy   [3];
    logic        flt   [3];
    logic [1:0]  dbg   [3];

    int ws_of [3] = '{1, 0, 3};

    logic [7:0] ref_mem [3][NBYTES];

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1), .BASE_ADDR(BASE)) u_ws1 (
        .clk(clk), .reset(rst), .mem_req_i(req[0]), .mem_we_i(we[0]), .mem_size_i(sz[0]),
        .mem_addr_i(addr[0]), .mem_wdata_i(wdata[0]), .mem_rdata_o(rd[0]),
        .mem_ready_o(rdy[0]), .mem_fault_o(flt[0]), .dbg_state_o(dbg[0]));

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .BASE_ADDR(BASE)) u_ws0 (
        .clk(clk), .reset(rst), .mem_req_i(req[1]), .mem_we_i(we[1]), .mem_size_i(sz[1]),
        .mem_addr_i(addr[1]), .mem_wdata_i(wdata[1]), .mem_rdata_o(rd[1]),
        .mem_ready_o(rdy[1]), .mem_fault_o(flt[1]), .dbg_state_o(dbg[1]));

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3), .BASE_ADDR(BASE)) u_ws3 (
        .clk(clk), .reset(rst), .mem_req_i(req[2]), .mem_we_i(we[2]), .mem_size_i(sz[2]),
        .mem_addr_i(addr[2]), .mem_wdata_i(wdata[2]), .mem_rdata_o(rd[2]),
        .mem_ready_o(rdy[2]), .mem_fault_o(flt[2]), .dbg_state_o(dbg[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes_of(input logic [2:0] s);
        if (s == 3'd0 || s == 3'd4) return 1;
        if (s == 3'd1 || s == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit m_fault(input bit w, input logic [2:0] s, input logic [31:0] a);
        if (s == 3'd3 || s == 3'd6 || s == 3'd7) return 1'b1;
        if (w && (s == 3'd4 || s == 3'd5)) return 1'b1;
        if (a % nbytes_of(s) != 0) return 1'b1;
        if (a < BASE || a - BASE >= NBYTES) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input int inst, input logic [2:0] s, input logic [31:0] a);
        int n;
        logic [31:0] v;
        n = nbytes_of(s);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[inst][a - BASE + i]) << (8 * i));
        if (s < 3'd4 && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic m_store(input int inst, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < nbytes_of(s); i++) ref_mem[inst][a - BASE + i] = d[8*i +: 8];
    endtask

    // Called #1 after a rising edge; returns #1 after the edge following the ready pulse.
    task automatic do_req(input int inst, input bit w, input logic [2:0] s, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] got);
        logic        exp_f;
        logic [31:0] exp_d;
        int          k;
        exp_f = m_fault(w, s, a);
        exp_d = (exp_f || w) ? 32'd0 : m_load(inst, s, a);
        req[inst] = 1'b1; we[inst] = w; sz[inst] = s; addr[inst] = a; wdata[inst] = d;
        @(posedge clk); #1;
        req[inst] = 1'b0;
        k = 0;
        while (rdy[inst] !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("latency", 32'(k), 32'(ws_of[inst]));
        check("fault", 32'(flt[inst]), 32'(exp_f));
        check("rdata", rd[inst], exp_d);
        got = rd[inst];
        @(posedge clk); #1;
        check("ready_one_cycle", 32'(rdy[inst]), 32'd0);
        check("fault_idle", 32'(flt[inst]), 32'd0);
        check("rdata_idle", rd[inst], 32'd0);
        if (w && !exp_f) m_store(inst, s, a, d);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [2:0]  s;
        bit          w;
        int          inst;

        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; sz[i] = 3'd0; addr[i] = 32'd0; wdata[i] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("reset_ready", 32'(rdy[i]), 32'd0);
            check("reset_fault", 32'(flt[i]), 32'd0);
            check("reset_rdata", rd[i], 32'd0);
            check("reset_state", 32'(dbg[i]), 32'd0);
        end

        // Give every instance known contents in the region the random phase uses.
        for (int i = 0; i < 3; i++)
            for (int wd = 0; wd < 64; wd++)
                do_req(i, 1'b1, 3'd2, BASE + 32'(wd * 4), $urandom, got);

        // Directed sequence on the one-wait-state instance.
        do_req(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, got);
        do_req(0, 1'b0, 3'd2, 32'h10, 32'h0, got);
        check("lw_10", got, 32'hDEADBEEF);
        do_req(0, 1'b0, 3'd0, 32'h13, 32'h0, got);
        check("lb_13", got, 32'hFFFFFFDE);
        do_req(0, 1'b0, 3'd4, 32'h13, 32'h0, got);
        check("lbu_13", got, 32'h000000DE);
        do_req(0, 1'b0, 3'd1, 32'h10, 32'h0, got);
        check("lh_10", got, 32'hFFFFBEEF);
        do_req(0, 1'b0, 3'd5, 32'h12, 32'h0, got);
        check("lhu_12", got, 32'h0000DEAD);
        do_req(0, 1'b1, 3'd0, 32'h11, 32'hFFFFFF55, got);
        do_req(0, 1'b0, 3'd2, 32'h10, 32'h0, got);
        check("lw_after_sb", got, 32'hDEAD55EF);
        do_req(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, got);
        do_req(0, 1'b1, 3'd2, 32'h12, 32'hCAFEF00D, got);
        do_req(0, 1'b0, 3'd1, 32'h01, 32'h0, got);
        do_req(0, 1'b1, 3'd4, 32'h14, 32'h0, got);
        do_req(0, 1'b0, 3'd3, 32'h10, 32'h0, got);
        do_req(0, 1'b0, 3'd2, 32'h10, 32'h0, got);
        check("lw_after_faults", got, 32'hDEADBEEF);
        do_req(0, 1'b0, 3'd2, BASE + 32'h400, 32'h0, got);
        do_req(0, 1'b0, 3'd2, BASE + 32'h3FC, 32'h0, got);

        // Store aborted by reset while waiting: no pulse, no write.
        if (m_load(0, 3'd2, 32'h20) == 32'h12345678) m_store(0, 3'd2, 32'h20, 32'h0);
        do_req(0, 1'b1, 3'd2, 32'h20, m_load(0, 3'd2, 32'h20), got);
        req[0] = 1'b1; we[0] = 1'b1; sz[0] = 3'd2; addr[0] = 32'h20; wdata[0] = 32'h12345678;
        @(posedge clk); #1;
        req[0] = 1'b0;
        check("abort_in_wait", 32'(dbg[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_state", 32'(dbg[0]), 32'd0);
        check("abort_ready", 32'(rdy[0]), 32'd0);
        #1 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("abort_no_pulse", 32'(rdy[0]), 32'd0);
        end
        do_req(0, 1'b0, 3'd2, 32'h20, 32'h0, got);
        check("abort_not_written", 32'(got == 32'h12345678), 32'd0);

        // Zero wait states with the request held: a response every second cycle.
        do_req(1, 1'b1, 3'd2, 32'h40, 32'hA5A5_0F0F, got);
        req[1] = 1'b1; we[1] = 1'b0; sz[1] = 3'd2; addr[1] = 32'h40; wdata[1] = 32'h0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("held_ready", 32'(rdy[1]), (c % 2 == 0) ? 32'd1 : 32'd0);
            check("held_rdata", rd[1], (c % 2 == 0) ? 32'hA5A5_0F0F : 32'd0);
        end
        req[1] = 1'b0;
        @(posedge clk); #1;

        // Three wait states: latency checked inside do_req.
        do_req(2, 1'b1, 3'd1, 32'h32, 32'h0000_8001, got);
        do_req(2, 1'b0, 3'd1, 32'h32, 32'h0, got);
        check("ws3_lh", got, 32'hFFFF8001);

        // Random requests on all instances.
        for (int n = 0; n < 90; n++) begin
            inst = $urandom_range(0, 2);
            w    = 1'($urandom_range(0, 1));
            s    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = BASE + 32'h400 + 32'($urandom_range(0, 255));
            else                           a = BASE + 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) a = a & ~32'(nbytes_of(s) - 1);
            do_req(inst, w, s, a, $urandom, got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
